context_scheduler: RTL and testbench

- Preemptive round-robin scheduler for the 4-context processor core.
- Holds the saved PC of each hardware process, a time-slice counter and a per-process active mask.
- Decides when the core switches context (explicit CTX instruction, slice expiry, or halt of the running process) and supplies the restored PC and new Proc_ID to the next-PC mux.
- Sits beside the Program_Counter on the Slow_Clock domain and replaces the ad-hoc context-save logic at top level.

---
 rtl/context_scheduler.sv | 159 +++++++++++++++
 tb/tb_context_scheduler.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/context_scheduler.sv
// Preemptive round-robin context scheduler: saved PCs, time slice and active mask.
// Optional interrupt-to-process-0 preemption is enabled by defining SCHED_IRQ_EN.
module context_scheduler #(
    parameter int NUM_PROCS = 4,
    parameter int PC_WIDTH = 13,
    parameter int BASE_STRIDE = 1024,
    parameter int QUANTUM_W = 16,
    parameter int QUANTUM_RST = 256,
    parameter logic [NUM_PROCS-1:0] INIT_ACTIVE = 'b1,
    localparam int ID_W = $clog2(NUM_PROCS)
) (
    input  logic                 Slow_Clock,
    input  logic                 Reset,
    input  logic                 Enable,
    input  logic                 Change_Context,
    input  logic [ID_W-1:0]      Target_ID,
    input  logic                 Halt,
    input  logic [PC_WIDTH-1:0]  Current_PC_In,
    input  logic [NUM_PROCS-1:0] Proc_Active_Set,
    input  logic                 Quantum_Load,
    input  logic [QUANTUM_W-1:0] Quantum_Value,
`ifdef SCHED_IRQ_EN
    input  logic                 Interrupt,
`endif
    output logic                 Switch,
    output logic [ID_W-1:0]      Next_ID,
    output logic [PC_WIDTH-1:0]  Context_PC,
    output logic [ID_W-1:0]      Proc_ID,
    output logic [NUM_PROCS-1:0] Active_Mask,
    output logic                 All_Halted,
    output logic [QUANTUM_W-1:0] Slice_Count
);
    typedef enum logic {ST_RUN, ST_ALL_HALTED} state_t;

    state_t                 state_q, state_d;
    logic [ID_W-1:0]        proc_id_q, proc_id_d;
    logic [NUM_PROCS-1:0]   mask_q, mask_d;
    logic [QUANTUM_W-1:0]   quantum_q, quantum_d;
    logic [QUANTUM_W-1:0]   slice_q, slice_d;
    logic                   all_halted_q, all_halted_d;
    logic [PC_WIDTH-1:0]    saved_q [NUM_PROCS];
    logic [PC_WIDTH-1:0]    saved_d [NUM_PROCS];

    logic                   rr_found, low_found;
    logic [ID_W-1:0]        rr_id, low_id, idx;
    logic                   sw;
    logic [ID_W-1:0]        nid;

    // Round-robin candidate (first active after current, excluding it) and lowest active ID.
    // Loops run downward so the nearest / lowest match is the last one written.
    always_comb begin
        rr_found  = 1'b0;
        rr_id     = proc_id_q;
        low_found = 1'b0;
        low_id    = '0;
        idx       = '0;
        for (int k = NUM_PROCS - 1; k >= 1; k--) begin
            idx = proc_id_q + ID_W'(k);
            if (mask_q[idx]) begin
                rr_found = 1'b1;
                rr_id    = idx;
            end
        end
        for (int i = NUM_PROCS - 1; i >= 0; i--) begin
            if (mask_q[i]) begin
                low_found = 1'b1;
                low_id    = ID_W'(i);
            end
        end
    end

    always_comb begin
        sw        = 1'b0;
        nid       = rr_id;
        state_d   = state_q;
        mask_d    = mask_q | Proc_Active_Set;
        saved_d   = saved_q;
        quantum_d = quantum_q;
        slice_d   = slice_q;
        case (state_q)
            ST_RUN: begin
                if (Change_Context) begin
                    sw             = 1'b1;
                    nid            = Target_ID;
                    mask_d[Target_ID] = 1'b1;
                end
`ifdef SCHED_IRQ_EN
                else if (Interrupt && proc_id_q != '0) begin
                    sw        = 1'b1;
                    nid       = '0;
                    mask_d[0] = 1'b1;
                end
`endif
                else if (Halt) begin
                    // Halt clear wins over a same-cycle spawn of the running process.
                    mask_d[proc_id_q] = 1'b0;
                    if (rr_found) sw = 1'b1;
                    else          state_d = ST_ALL_HALTED;
                end else if (Enable && slice_q == '0 && rr_found) begin
                    sw = 1'b1;
                end
            end
            ST_ALL_HALTED: begin
`ifdef SCHED_IRQ_EN
                if (Interrupt) mask_d[0] = 1'b1;
`endif
                if (low_found) begin
                    sw      = 1'b1;
                    nid     = low_id;
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_RUN;
        endcase

        if (sw) begin
            saved_d[proc_id_q] = Current_PC_In;
            slice_d            = quantum_q - 1'b1;
        end else if (state_q == ST_RUN && Enable) begin
            slice_d = (slice_q == '0) ? quantum_q - 1'b1 : slice_q - 1'b1;
        end

        // A new quantum only takes effect at the next reload.
        if (Quantum_Load)
            quantum_d = (Quantum_Value == '0) ? QUANTUM_W'(1) : Quantum_Value;

        proc_id_d    = sw ? nid : proc_id_q;
        all_halted_d = (state_d == ST_ALL_HALTED);
    end

    always_ff @(posedge Slow_Clock or posedge Reset) begin
        if (Reset) begin
            state_q      <= ST_RUN;
            proc_id_q    <= '0;
            mask_q       <= INIT_ACTIVE;
            quantum_q    <= QUANTUM_W'(QUANTUM_RST);
            slice_q      <= QUANTUM_W'(QUANTUM_RST - 1);
            all_halted_q <= 1'b0;
            for (int i = 0; i < NUM_PROCS; i++)
                saved_q[i] <= PC_WIDTH'(i * BASE_STRIDE);
        end else begin
            state_q      <= state_d;
            proc_id_q    <= proc_id_d;
            mask_q       <= mask_d;
            quantum_q    <= quantum_d;
            slice_q      <= slice_d;
            all_halted_q <= all_halted_d;
            saved_q      <= saved_d;
        end
    end

    assign Switch      = sw;
    assign Next_ID     = nid;
    assign Context_PC  = saved_q[nid];
    assign Proc_ID     = proc_id_q;
    assign Active_Mask = mask_q;
    assign All_Halted  = all_halted_q;
    assign Slice_Count = slice_q;
endmodule

// File: tb/tb_context_scheduler.sv
// Directed plus randomized bench for context_scheduler against a per-cycle behavioural model.
module tb_context_scheduler;
    logic        clk = 1'b0;
    logic        rst;
    logic        en, ctx, halt, qload;
    logic [1:0]  tgt;
    logic [12:0] cur_pc;
    logic [3:0]  aset;
    logic [15:0] qval;
    logic        sw_o, halted_o;
    logic [1:0]  nid_o, pid_o;
    logic [12:0] cpc_o;
    logic [3:0]  mask_o;
    logic [15:0] slice_o;

    int checks = 0;
    int failures = 0;

    // Behavioural model state
    int     m_pc[4];
    int     m_pid, m_slice, m_quant;
    bit [3:0] m_mask;
    bit     m_halted;

    // Observations from the most recent step, for directed checks
    logic        last_sw;
    logic [1:0]  last_nid;
    logic [12:0] last_cpc;

    context_scheduler dut (
        .Slow_Clock(clk), .Reset(rst), .Enable(en), .Change_Context(ctx),
        .Target_ID(tgt), .Halt(halt), .Current_PC_In(cur_pc),
        .Proc_Active_Set(aset), .Quantum_Load(qload), .Quantum_Value(qval),
        .Switch(sw_o), .Next_ID(nid_o), .Context_PC(cpc_o), .Proc_ID(pid_o),
        .Active_Mask(mask_o), .All_Halted(halted_o), .Slice_Count(slice_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_pc[i] = i * 1024;
        m_pid = 0; m_mask = 4'b0001; m_quant = 256; m_slice = 255; m_halted = 0;
    endtask

    function automatic int rr_pick();
        for (int k = 1; k < 4; k++)
            if (m_mask[(m_pid + k) % 4]) return (m_pid + k) % 4;
        return -1;
    endfunction

    task automatic check_regs(input string tag);
        chk({tag, "_pid"}, 32'(pid_o), 32'(m_pid));
        chk({tag, "_mask"}, 32'(mask_o), 32'(m_mask));
        chk({tag, "_halted"}, 32'(halted_o), 32'(m_halted));
        chk({tag, "_slice"}, 32'(slice_o), 32'(m_slice));
    endtask

    // One Slow_Clock cycle: drive, check combinational outputs, advance model, check registers.
    task automatic step(input bit e, input bit c, input logic [1:0] t, input bit h,
                        input logic [12:0] p, input logic [3:0] s, input bit ql, input logic [15:0] qv);
        int r, e_nid, n_slice;
        bit e_sw;
        bit [3:0] n_mask;
        @(negedge clk);
        en = e; ctx = c; tgt = t; halt = h; cur_pc = p; aset = s; qload = ql; qval = qv;
        #1;
        r = rr_pick();
        e_sw = 0; e_nid = 0;
        if (!m_halted) begin
            if (c) begin e_sw = 1; e_nid = t; end
            else if (h) begin if (r >= 0) begin e_sw = 1; e_nid = r; end end
            else if (e && m_slice == 0 && r >= 0) begin e_sw = 1; e_nid = r; end
        end else if (m_mask != 0) begin
            e_sw = 1;
            for (int i = 3; i >= 0; i--) if (m_mask[i]) e_nid = i;
        end
        last_sw = sw_o; last_nid = nid_o; last_cpc = cpc_o;
        chk("switch", 32'(sw_o), 32'(e_sw));
        if (e_sw) begin
            chk("next_id", 32'(nid_o), 32'(e_nid));
            chk("context_pc", 32'(cpc_o), 32'(m_pc[e_nid]));
        end
        n_mask = m_mask | s;
        if (!m_halted && c) n_mask[t] = 1'b1;
        else if (!m_halted && h) n_mask[m_pid] = 1'b0;
        if (e_sw) n_slice = m_quant - 1;
        else if (!m_halted && e) n_slice = (m_slice == 0) ? m_quant - 1 : m_slice - 1;
        else n_slice = m_slice;
        if (e_sw) begin m_pc[m_pid] = p; m_pid = e_nid; end
        if (!m_halted && !c && h && r < 0) m_halted = 1;
        else if (m_halted && e_sw) m_halted = 0;
        m_mask = n_mask; m_slice = n_slice;
        if (ql) m_quant = (qv == 0) ? 1 : qv;
        @(posedge clk);
        #1;
        check_regs("reg");
    endtask

    task automatic idle(input bit e);
        step(e, 0, 2'd0, 0, 13'd0, 4'd0, 0, 16'd0);
    endtask

    task automatic async_reset();
        @(negedge clk);
        en = 0; ctx = 0; halt = 0; aset = 0; qload = 0;
        #2 rst = 1;
        #1 model_reset();
        check_regs("rst");
        @(negedge clk);
        rst = 0;
    endtask

    initial begin
        int nsw;
        logic [1:0]  seq_nid[$];
        logic [12:0] seq_cpc[$];
        rst = 1; en = 0; ctx = 0; tgt = 0; halt = 0; cur_pc = 0; aset = 0; qload = 0; qval = 0;
        model_reset();
        #1 check_regs("reset");
        @(negedge clk);
        rst = 0;

        // Single process, default quantum: never switches, counter wraps.
        nsw = 0;
        for (int i = 0; i < 1000; i++) begin
            idle(1);
            if (last_sw) nsw++;
        end
        chk("t1_no_switch", 32'(nsw), 32'd0);
        chk("t1_pid", 32'(pid_o), 32'd0);

        // Spawn 1,2 and shrink quantum to 4.
        step(1, 0, 2'd0, 0, 13'd0, 4'b0110, 1, 16'd4);
        for (int i = 0; i < 600 && seq_nid.size() < 4; i++) begin
            step(1, 0, 2'd0, 0, 13'($urandom), 4'd0, 0, 16'd0);
            if (last_sw) begin seq_nid.push_back(last_nid); seq_cpc.push_back(last_cpc); end
        end
        chk("t2_switch_count", 32'(seq_nid.size()), 32'd4);
        if (seq_nid.size() == 4) begin
            chk("t2_seq0", 32'(seq_nid[0]), 32'd1);
            chk("t2_seq1", 32'(seq_nid[1]), 32'd2);
            chk("t2_seq2", 32'(seq_nid[2]), 32'd0);
            chk("t2_seq3", 32'(seq_nid[3]), 32'd1);
            chk("t2_cpc0", 32'(seq_cpc[0]), 32'd1024);
            chk("t2_cpc1", 32'(seq_cpc[1]), 32'd2048);
        end
        // Quantum 4: slices are exactly 4 cycles apart.
        nsw = 0;
        for (int i = 0; i < 4; i++) begin idle(1); if (last_sw) nsw++; end
        chk("t2_period", 32'(nsw), 32'd1);

        // CTX to 3 then back to 0.
        async_reset();
        step(0, 1, 2'd3, 0, 13'd37, 4'd0, 0, 16'd0);
        chk("t3_sw", 32'(last_sw), 32'd1);
        chk("t3_cpc", 32'(last_cpc), 32'd3072);
        chk("t3_pid", 32'(pid_o), 32'd3);
        step(0, 1, 2'd0, 0, 13'd100, 4'd0, 0, 16'd0);
        chk("t3_back_cpc", 32'(last_cpc), 32'd37);

        // Halt chain into ALL_HALTED and wake by spawn.
        async_reset();
        step(0, 0, 2'd0, 0, 13'd0, 4'b0010, 0, 16'd0);
        step(0, 1, 2'd1, 0, 13'd5, 4'd0, 0, 16'd0);
        step(0, 0, 2'd0, 1, 13'd9, 4'd0, 0, 16'd0);
        chk("t4_halt_sw", 32'(last_sw), 32'd1);
        chk("t4_halt_nid", 32'(last_nid), 32'd0);
        chk("t4_mask", 32'(mask_o), 32'd1);
        step(1, 0, 2'd0, 1, 13'd11, 4'd0, 0, 16'd0);
        chk("t4_last_halt_sw", 32'(last_sw), 32'd0);
        chk("t4_all_halted", 32'(halted_o), 32'd1);
        nsw = 0;
        for (int i = 0; i < 3; i++) begin step(1, 1, 2'd3, 0, 13'd0, 4'd0, 0, 16'd0); if (last_sw) nsw++; end
        chk("t4_frozen_sw", 32'(nsw), 32'd0);
        step(1, 0, 2'd0, 0, 13'd0, 4'b0100, 0, 16'd0);
        idle(0);
        chk("t4_wake_sw", 32'(last_sw), 32'd1);
        chk("t4_wake_nid", 32'(last_nid), 32'd2);
        chk("t4_wake_pid", 32'(pid_o), 32'd2);
        chk("t4_wake_halted", 32'(halted_o), 32'd0);

        // Halt with CTX: CTX wins, halting process stays active.
        step(0, 0, 2'd0, 0, 13'd0, 4'b0001, 0, 16'd0);
        step(0, 1, 2'd0, 0, 13'd77, 4'd0, 0, 16'd0);
        step(0, 1, 2'd2, 1, 13'd88, 4'd0, 0, 16'd0);
        chk("t5_nid", 32'(last_nid), 32'd2);
        chk("t5_pid", 32'(pid_o), 32'd2);
        chk("t5_mask0", 32'(mask_o[0]), 32'd1);

        // Reset mid-slice restores the saved PC table.
        for (int i = 0; i < 10; i++) idle(1);
        chk("t6_pre_pid", 32'(pid_o), 32'd2);
        async_reset();
        step(0, 1, 2'd0, 0, 13'd500, 4'd0, 0, 16'd0);
        chk("t6_pc0", 32'(last_cpc), 32'd0);
        step(0, 1, 2'd1, 0, 13'd501, 4'd0, 0, 16'd0);
        chk("t6_pc1", 32'(last_cpc), 32'd1024);
        step(0, 1, 2'd2, 0, 13'd502, 4'd0, 0, 16'd0);
        chk("t6_pc2", 32'(last_cpc), 32'd2048);
        step(0, 1, 2'd3, 0, 13'd503, 4'd0, 0, 16'd0);
        chk("t6_pc3", 32'(last_cpc), 32'd3072);

        // Randomized traffic against the model.
        for (int i = 0; i < 2500; i++) begin
            step(($urandom_range(0, 7) != 0),
                 ($urandom_range(0, 11) == 0),
                 2'($urandom),
                 ($urandom_range(0, 13) == 0),
                 13'($urandom),
                 ($urandom_range(0, 9) == 0) ? 4'($urandom) : 4'd0,
                 ($urandom_range(0, 15) == 0),
                 16'($urandom_range(0, 6)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
